// File: rtl/spike_rate_decoder.sv
// -----------------------------------------------------------------------------
// spike_rate_decoder
//   Rate decoder for the tinysnn neuron path. Counts rising edges of spike_in
//   over a window of 2**WINDOW_LOG2 enabled cycles and publishes the count on
//   rate_out together with a one-cycle rate_valid strobe.
//
//   Optional feature: define SPIKE_RATE_SMOOTH_EN to publish the average of the
//   current and previous completed window counts instead of the raw count.
//
// Ports
//   clk         in   1      clock, rising edge
//   rst_n       in   1      asynchronous active-low reset
//   ena         in   1      decoder enable; low aborts the current window
//   clear       in   1      synchronous window restart (priority over ena)
//   spike_in    in   1      spike train (pulse or level)
//   rate_out    out  CNT_W  count (or smoothed count) of last completed window
//   rate_valid  out  1      one-cycle strobe: rate_out updated this cycle
//   sat         out  1      last completed window saturated
//   busy        out  1      window in progress
// -----------------------------------------------------------------------------
module spike_rate_decoder #(
    parameter int unsigned WINDOW_LOG2 = 8,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             clear,
    input  logic             spike_in,
    output logic [CNT_W-1:0] rate_out,
    output logic             rate_valid,
    output logic             sat,
    output logic             busy
);

    localparam int unsigned IDX_W = WINDOW_LOG2;
    localparam logic [IDX_W-1:0] IDX_LAST = {IDX_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wsat_q, wsat_d;
    logic               spk_q, spk_d;
    logic [CNT_W-1:0]   rate_q, rate_d;
    logic               valid_q, valid_d;
    logic               sat_q, sat_d;
    logic               busy_q, busy_d;

    // Working values for the current enabled cycle
    logic               spk_edge_c;
    logic [IDX_W-1:0]   idx_cur_c;
    logic [CNT_W-1:0]   cnt_nxt_c;
    logic               wsat_nxt_c;

`ifdef SPIKE_RATE_SMOOTH_EN
    logic [CNT_W-1:0]   prev_q, prev_d;
    logic [CNT_W:0]     sum_c;
`endif

    // Next-state and output computation
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        wsat_d     = wsat_q;
        rate_d     = rate_q;
        sat_d      = sat_q;
        valid_d    = 1'b0;
        busy_d     = 1'b0;
        spk_d      = spike_in;
`ifdef SPIKE_RATE_SMOOTH_EN
        prev_d     = prev_q;
        sum_c      = '0;
`endif

        spk_edge_c = spike_in & ~spk_q;
        // Index is held at zero while idle, so the first enabled cycle is index 0
        idx_cur_c  = (state_q == ST_RUN) ? idx_q : '0;

        // Saturating edge count; sat marks an edge lost at the ceiling
        cnt_nxt_c  = cnt_q;
        wsat_nxt_c = wsat_q;
        if (spk_edge_c) begin
            if (cnt_q == CNT_MAX) begin
                wsat_nxt_c = 1'b1;
            end else begin
                cnt_nxt_c = cnt_q + CNT_W'(1);
            end
        end

        if (clear || !ena) begin
            // Abort the window; published result is held
            state_d = ST_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            wsat_d  = 1'b0;
        end else begin
            state_d = ST_RUN;
            busy_d  = 1'b1;
            if (idx_cur_c == IDX_LAST) begin
                // Window close: publish and restart with no gap
`ifdef SPIKE_RATE_SMOOTH_EN
                sum_c  = {1'b0, cnt_nxt_c} + {1'b0, prev_q};
                rate_d = CNT_W'(sum_c >> 1);
                prev_d = cnt_nxt_c;
`else
                rate_d = cnt_nxt_c;
`endif
                sat_d   = wsat_nxt_c;
                valid_d = 1'b1;
                idx_d   = '0;
                cnt_d   = '0;
                wsat_d  = 1'b0;
            end else begin
                idx_d  = idx_cur_c + IDX_W'(1);
                cnt_d  = cnt_nxt_c;
                wsat_d = wsat_nxt_c;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            wsat_q  <= 1'b0;
            spk_q   <= 1'b0;
            rate_q  <= '0;
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            wsat_q  <= wsat_d;
            spk_q   <= spk_d;
            rate_q  <= rate_d;
            valid_q <= valid_d;
            sat_q   <= sat_d;
            busy_q  <= busy_d;
        end
    end

`ifdef SPIKE_RATE_SMOOTH_EN
    // Previous window count survives clear and ena drops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end
`endif

    assign rate_out   = rate_q;
    assign rate_valid = valid_q;
    assign sat        = sat_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// -----------------------------------------------------------------------------
// tb_spike_rate_decoder
//   Self-checking bench for spike_rate_decoder. A window-level reference model
//   (queue of per-cycle edge flags) shadows the N=16 instance every cycle; a
//   second instance with WINDOW_LOG2=10 covers saturation. Table rows and
//   hand-written sequences check known window results directly.
// -----------------------------------------------------------------------------
module tb_spike_rate_decoder;

    localparam int NWIN  = 16;
    localparam int NBIG  = 1024;
    localparam int MAXC  = 255;

    logic       clk;
    logic       rst_n;
    logic       ena, clear, spike_in;
    logic [7:0] rate_out;
    logic       rate_valid, sat, busy;

    logic       ena2, spike2;
    logic [7:0] rate2;
    logic       valid2, sat2, busy2;

    int checks;
    int errors;
    bit chk_en;

    spike_rate_decoder #(.WINDOW_LOG2(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .clear      (clear),
        .spike_in   (spike_in),
        .rate_out   (rate_out),
        .rate_valid (rate_valid),
        .sat        (sat),
        .busy       (busy)
    );

    spike_rate_decoder #(.WINDOW_LOG2(10), .CNT_W(8)) dut_big (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena2),
        .clear      (1'b0),
        .spike_in   (spike2),
        .rate_out   (rate2),
        .rate_valid (valid2),
        .sat        (sat2),
        .busy       (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the current window is a queue of edge flags
    logic       m_spk;
    bit         mq[$];
    bit         m_e;
    int         m_tot, m_raw, m_prev;
    logic [7:0] m_rate;
    logic       m_valid, m_sat, m_busy;

    initial begin
        m_spk = 0; m_prev = 0; m_rate = 0; m_valid = 0; m_sat = 0; m_busy = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_spk = 0; mq.delete(); m_prev = 0;
                m_rate = 0; m_valid = 0; m_sat = 0; m_busy = 0;
            end else begin
                m_e     = spike_in && !m_spk;
                m_spk   = spike_in;
                m_valid = 0;
                if (clear || !ena) begin
                    mq.delete();
                    m_busy = 0;
                end else begin
                    m_busy = 1;
                    mq.push_back(m_e);
                    if (mq.size() == NWIN) begin
                        m_tot = 0;
                        foreach (mq[i]) m_tot += int'(mq[i]);
                        m_raw = (m_tot > MAXC) ? MAXC : m_tot;
                        m_sat = (m_tot > MAXC);
`ifdef SPIKE_RATE_SMOOTH_EN
                        m_rate = 8'((m_raw + m_prev) / 2);
`else
                        m_rate = 8'(m_raw);
`endif
                        m_prev  = m_raw;
                        m_valid = 1;
                        mq.delete();
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("model rate_out",   32'(rate_out),   32'(m_rate));
                check("model rate_valid", 32'(rate_valid), 32'(m_valid));
                check("model sat",        32'(sat),        32'(m_sat));
                check("model busy",       32'(busy),       32'(m_busy));
            end
        end
    end

    typedef struct {
        int period;   // spike pulse every 'period' cycles, 0 = none
        int exp_raw;  // expected raw count of the window
    } row_t;

    row_t rows[8];
    int   prev_raw;
    int   exp_r;
    int   nstrobe;
    int   first_at;

    // Apply inputs, then step to the next falling edge
    task automatic tick(input logic e, input logic c, input logic s);
        ena = e; clear = c; spike_in = s;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 0; ena = 0; clear = 0; spike_in = 0; ena2 = 0; spike2 = 0;
        checks = 0; errors = 0; chk_en = 0;
        repeat (2) @(negedge clk);
        check("reset rate_out", 32'(rate_out), 32'd0);
        check("reset busy",     32'(busy),     32'd0);
        rst_n  = 1;
        chk_en = 1;

        // Table: one full window per row, preceded by an idle cycle
        rows[0] = '{4, 4};  rows[1] = '{8, 2};  rows[2] = '{3, 6};  rows[3] = '{16, 1};
        rows[4] = '{2, 8};  rows[5] = '{4, 4};  rows[6] = '{0, 0};  rows[7] = '{1, 1};
        prev_raw = 0;
        for (int r = 0; r < 8; r++) begin
            tick(0, 0, 0);
            check("tbl idle busy", 32'(busy), 32'd0);
            for (int i = 0; i < NWIN; i++) begin
                tick(1, 0, (rows[r].period != 0) && (i % rows[r].period == 0));
                if (i == NWIN - 2) check("tbl early valid", 32'(rate_valid), 32'd0);
            end
`ifdef SPIKE_RATE_SMOOTH_EN
            exp_r = (rows[r].exp_raw + prev_raw) / 2;
`else
            exp_r = rows[r].exp_raw;
`endif
            prev_raw = rows[r].exp_raw;
            check("tbl valid",    32'(rate_valid), 32'd1);
            check("tbl rate_out", 32'(rate_out),   32'(exp_r));
            check("tbl sat",      32'(sat),        32'd0);
            check("tbl busy",     32'(busy),       32'd1);
        end

        // Async reset mid-window with spikes active
        tick(0, 0, 0);
        for (int i = 0; i < 5; i++) tick(1, 0, i[0]);
        #2 rst_n = 0;
        #1;
        check("async rate_out",   32'(rate_out),   32'd0);
        check("async rate_valid", 32'(rate_valid), 32'd0);
        check("async sat",        32'(sat),        32'd0);
        check("async busy",       32'(busy),       32'd0);
        @(negedge clk);
        rst_n = 1;
        tick(0, 0, 0);

        // Level held high 40 cycles: first window 1 edge, then 0
        nstrobe = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1, 0, 1);
            if (i == 15 || i == 31) begin
                check("level valid", 32'(rate_valid), 32'd1);
`ifdef SPIKE_RATE_SMOOTH_EN
                check("level rate", 32'(rate_out), 32'd0);
`else
                check("level rate", 32'(rate_out), (i == 15) ? 32'd1 : 32'd0);
`endif
            end
            if (rate_valid) nstrobe++;
        end
        check("level strobes", 32'(nstrobe), 32'd2);

        // Periodic spikes: strobe every 16 cycles, rate 4
        tick(0, 0, 0);
        nstrobe = 0;
        for (int i = 0; i < 48; i++) begin
            tick(1, 0, (i % 4) == 0);
            if (rate_valid) begin
                nstrobe++;
                check("periodic strobe pos", 32'(i % NWIN), 32'(NWIN - 1));
            end
        end
        check("periodic strobes", 32'(nstrobe), 32'd3);
        check("periodic rate", 32'(rate_out), 32'd4);

        // ena dropped at index 7 for 3 cycles, then reasserted
        tick(0, 0, 0);
        nstrobe = 0;
        for (int i = 0; i < 7; i++) begin tick(1, 0, i[0]); if (rate_valid) nstrobe++; end
        for (int i = 0; i < 3; i++) begin tick(0, 0, 0);    if (rate_valid) nstrobe++; end
        check("drop no strobe", 32'(nstrobe), 32'd0);
        first_at = -1;
        for (int i = 0; i < 20; i++) begin
            tick(1, 0, i[1]);
            if (rate_valid && first_at < 0) first_at = i;
        end
        check("reassert latency", 32'(first_at), 32'(NWIN - 1));

        // clear on the close cycle discards the window
        tick(0, 0, 0);
        nstrobe = 0;
        for (int i = 0; i < NWIN - 1; i++) begin tick(1, 0, i[0]); if (rate_valid) nstrobe++; end
        tick(1, 1, 0);
        if (rate_valid) nstrobe++;
        check("clear busy", 32'(busy), 32'd0);
        check("clear no strobe", 32'(nstrobe), 32'd0);
        first_at = -1;
        for (int i = 0; i < 20; i++) begin
            tick(1, 0, 0);
            if (rate_valid && first_at < 0) first_at = i;
        end
        check("post-clear latency", 32'(first_at), 32'(NWIN - 1));

        // Big window: 512 edges saturate an 8-bit count
        tick(0, 0, 0);
        nstrobe = 0;
        for (int i = 0; i < NBIG; i++) begin
            ena2 = 1; spike2 = ~i[0];
            @(negedge clk);
            if (valid2) nstrobe++;
        end
        check("big valid", 32'(valid2), 32'd1);
        check("big strobes", 32'(nstrobe), 32'd1);
`ifdef SPIKE_RATE_SMOOTH_EN
        check("big rate", 32'(rate2), 32'd127);
`else
        check("big rate", 32'(rate2), 32'd255);
`endif
        check("big sat", 32'(sat2), 32'd1);
        ena2 = 0; spike2 = 0;

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom % 16) != 0, ($urandom % 40) == 0, ($urandom % 3) == 0);
        end
        tick(0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
